// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared types and constants for the CDB arbiter.
//   ROB_IDX_W, PREG_W, DATA_W : default field widths of a CDB packet
//   cdb_pkt_t                 : one result packet (rob_idx, preg, result)
//   ptr_w()                   : width of a round-robin pointer over n requesters
package cdb_arbiter_pkg;

  localparam int ROB_IDX_W = 4;
  localparam int PREG_W    = 6;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    preg;
    logic [DATA_W-1:0]    result;
  } cdb_pkt_t;

  // A pointer always needs at least one bit, even for two requesters.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// cdb_arbiter_rr_pick: combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority requester this cycle
//   gnt : one-hot grant (zero when nothing requests)
//   idx : index of the granted requester (zero when nothing requests)
//   any : at least one request present
module cdb_arbiter_rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int PTR_W  = ptr_w(NUM_FU)
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_FU-1:0] gnt,
  output logic [PTR_W-1:0]  idx,
  output logic              any
);

  int               pos;
  logic [PTR_W-1:0] cand;

  // Scan ptr, ptr+1, ... (wrapping) and take the first requester found.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    pos  = 0;
    cand = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      pos  = (int'(ptr) + k) % NUM_FU;
      cand = PTR_W'(pos);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that puts at most one FU result per cycle
// onto the registered common data bus feeding the complete stage.
//   clk, rst_n (sync, active-low), flush (kills the in-flight packet)
//   fu_valid/fu_ready          : per-FU valid/ready handshake, grant one-hot
//   fu_rob_idx/fu_preg/fu_result : packed per-FU payload, FU i at slice i
//   cdb_valid/cdb_ready        : registered packet toward complete stage
//   cdb_rob_idx/cdb_preg/cdb_result : registered packet payload
// Optional: define CDB_STALL_CNT_EN to add stall_cnt[15:0], a saturating
// count of edges where some FU requested but nothing was transferred.
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int ROB_IDX_W = cdb_arbiter_pkg::ROB_IDX_W,
  parameter int PREG_W    = cdb_arbiter_pkg::PREG_W,
  parameter int DATA_W    = cdb_arbiter_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NUM_FU-1:0]           fu_valid,
  output logic [NUM_FU-1:0]           fu_ready,
  input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx,
  input  logic [NUM_FU*PREG_W-1:0]    fu_preg,
  input  logic [NUM_FU*DATA_W-1:0]    fu_result,
  output logic                        cdb_valid,
  input  logic                        cdb_ready,
  output logic [ROB_IDX_W-1:0]        cdb_rob_idx,
  output logic [PREG_W-1:0]           cdb_preg,
  output logic [DATA_W-1:0]           cdb_result
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int PTR_W = cdb_arbiter_pkg::ptr_w(NUM_FU);
  localparam logic [PTR_W-1:0] LAST_FU = PTR_W'(NUM_FU - 1);

  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_FU-1:0]    pick_gnt;
  logic [PTR_W-1:0]     win_idx;
  logic                 pick_any;
  logic                 slot_free;
  logic                 grant_en;
  logic                 xfer;
  logic [ROB_IDX_W-1:0] rob_arr [NUM_FU];
  logic [PREG_W-1:0]    preg_arr [NUM_FU];
  logic [DATA_W-1:0]    res_arr [NUM_FU];

  for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
    assign rob_arr[g]  = fu_rob_idx[g*ROB_IDX_W +: ROB_IDX_W];
    assign preg_arr[g] = fu_preg[g*PREG_W +: PREG_W];
    assign res_arr[g]  = fu_result[g*DATA_W +: DATA_W];
  end

  cdb_arbiter_rr_pick #(
    .NUM_FU (NUM_FU),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req (fu_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (win_idx),
    .any (pick_any)
  );

  // Grant only into a free (or draining) slot, never during flush or reset.
  always_comb begin
    slot_free = !cdb_valid || cdb_ready;
    grant_en  = slot_free && !flush && rst_n;
    if (grant_en) begin
      fu_ready = pick_gnt;
      xfer     = pick_any;
    end else begin
      fu_ready = '0;
      xfer     = 1'b0;
    end
  end

  // CDB packet register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_preg    <= '0;
      cdb_result  <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      // Payload is left stale; only the valid bit matters downstream.
      cdb_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      cdb_valid   <= 1'b1;
      cdb_rob_idx <= rob_arr[win_idx];
      cdb_preg    <= preg_arr[win_idx];
      cdb_result  <= res_arr[win_idx];
      rr_ptr      <= (win_idx == LAST_FU) ? '0 : win_idx + PTR_W'(1);
    end else if (cdb_ready) begin
      cdb_valid <= 1'b0;
    end
  end

`ifdef CDB_STALL_CNT_EN
  // Saturating count of edges where a request was pending but not taken.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      stall_cnt <= 16'h0000;
    end else if ((|fu_valid) && !xfer && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed table plus randomized run of cdb_arbiter against
// a cycle-level behavioural model (pending packet, pointer, stall count).
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    flush = 1'b0;
  logic [N-1:0]            fu_valid = '0;
  logic [N-1:0]            fu_ready;
  logic [N*ROB_IDX_W-1:0]  fu_rob_idx = '0;
  logic [N*PREG_W-1:0]     fu_preg = '0;
  logic [N*DATA_W-1:0]     fu_result = '0;
  logic                    cdb_valid;
  logic                    cdb_ready = 1'b0;
  logic [ROB_IDX_W-1:0]    cdb_rob_idx;
  logic [PREG_W-1:0]       cdb_preg;
  logic [DATA_W-1:0]       cdb_result;
`ifdef CDB_STALL_CNT_EN
  logic [15:0]             stall_cnt;
`endif

  cdb_arbiter #(.NUM_FU(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .fu_valid    (fu_valid),
    .fu_ready    (fu_ready),
    .fu_rob_idx  (fu_rob_idx),
    .fu_preg     (fu_preg),
    .fu_result   (fu_result),
    .cdb_valid   (cdb_valid),
    .cdb_ready   (cdb_ready),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_preg    (cdb_preg),
    .cdb_result  (cdb_result)
`ifdef CDB_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic     m_cv = 1'b0;
  cdb_pkt_t m_pkt = '0;
  int       m_ptr = 0;
  int       m_stall = 0;
  logic [N-1:0] exp_rdy;
  logic [N-1:0] seen_rdy;

  typedef struct {
    logic         rst;
    logic         fl;
    logic [N-1:0] val;
    logic         crdy;
    logic [N-1:0] exp_ready;
    logic         exp_cv;
    int           exp_src;
    int           exp_ptr;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_pay(input int i, input logic [3:0] r, input logic [5:0] p, input logic [31:0] d);
    fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W] = r;
    fu_preg[i*PREG_W +: PREG_W]          = p;
    fu_result[i*DATA_W +: DATA_W]        = d;
  endtask

  // Grant the model expects: first requester at or after the pointer, wrapping.
  function automatic logic [N-1:0] ref_grant(input int ptr);
    logic [N-1:0] g;
    g = '0;
    if (rst_n && !flush && !(m_cv && !cdb_ready)) begin
      for (int k = 0; k < N; k++) begin
        if (g == '0 && fu_valid[(ptr + k) % N]) g[(ptr + k) % N] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_edge();
    int w;
    w = -1;
    for (int i = 0; i < N; i++) if (exp_rdy[i]) w = i;
    if (!rst_n) begin
      m_cv = 1'b0; m_pkt = '0; m_ptr = 0; m_stall = 0;
    end else if (flush) begin
      m_cv = 1'b0; m_ptr = 0; m_stall = 0;
    end else if (w >= 0) begin
      m_cv = 1'b1;
      m_pkt.rob_idx = fu_rob_idx[w*ROB_IDX_W +: ROB_IDX_W];
      m_pkt.preg    = fu_preg[w*PREG_W +: PREG_W];
      m_pkt.result  = fu_result[w*DATA_W +: DATA_W];
      m_ptr = (w + 1) % N;
    end else begin
      if (cdb_ready) m_cv = 1'b0;
      if ((|fu_valid) && m_stall < 65535) m_stall++;
    end
  endtask

  // One clock: inputs already set just after a rising edge.
  task automatic cycle();
    @(negedge clk);
    exp_rdy  = ref_grant(m_ptr);
    seen_rdy = fu_ready;
    chk("fu_ready", 32'(fu_ready), 32'(exp_rdy));
    model_edge();
    @(posedge clk);
    #1;
    chk("cdb_valid", 32'(cdb_valid), 32'(m_cv));
    if (m_cv) begin
      chk("cdb_rob_idx", 32'(cdb_rob_idx), 32'(m_pkt.rob_idx));
      chk("cdb_preg", 32'(cdb_preg), 32'(m_pkt.preg));
      chk("cdb_result", cdb_result, m_pkt.result);
    end
`ifdef CDB_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
  endtask

  logic [N-1:0] pend;

  initial begin
    // rob = i+3, preg = i+10, result = C0DE0000+i for the table rows
    tbl[0]  = '{1'b1, 1'b1, 4'hF,    1'b1, 4'b0000, 1'b0, -1, 0};
    tbl[1]  = '{1'b1, 1'b0, 4'hF,    1'b1, 4'b0001, 1'b1,  0, 1};
    tbl[2]  = '{1'b1, 1'b0, 4'hF,    1'b1, 4'b0010, 1'b1,  1, 2};
    tbl[3]  = '{1'b1, 1'b0, 4'hF,    1'b1, 4'b0100, 1'b1,  2, 3};
    tbl[4]  = '{1'b1, 1'b0, 4'hF,    1'b1, 4'b1000, 1'b1,  3, 0};
    tbl[5]  = '{1'b1, 1'b0, 4'hF,    1'b1, 4'b0001, 1'b1,  0, 1};
    tbl[6]  = '{1'b1, 1'b0, 4'hF,    1'b1, 4'b0010, 1'b1,  1, 2};
    tbl[7]  = '{1'b1, 1'b0, 4'b1001, 1'b0, 4'b0000, 1'b1,  1, 2};
    tbl[8]  = '{1'b1, 1'b0, 4'b1001, 1'b0, 4'b0000, 1'b1,  1, 2};
    tbl[9]  = '{1'b1, 1'b0, 4'b1001, 1'b0, 4'b0000, 1'b1,  1, 2};
    tbl[10] = '{1'b1, 1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1,  3, 0};
    tbl[11] = '{1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1,  0, 1};
    tbl[12] = '{1'b1, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1,  0, 1};
    tbl[13] = '{1'b1, 1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, -1, 0};
    tbl[14] = '{1'b1, 1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1,  0, 1};
    tbl[15] = '{1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1,  3, 0};
    tbl[16] = '{1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, -1, 0};
    tbl[17] = '{1'b0, 1'b1, 4'hF,    1'b1, 4'b0000, 1'b0, -1, 0};

    @(posedge clk);
    #1;

    // Reset held two cycles with requests present: no grant leaks out.
    rst_n = 1'b0; fu_valid = 4'hF; cdb_ready = 1'b1;
    cycle();
    cycle();
    chk("rst_fu_ready", 32'(seen_rdy), 32'h0);
    rst_n = 1'b1; fu_valid = 4'h0;
    cycle();
    chk("idle_valid", 32'(cdb_valid), 32'h0);
    chk("idle_rob", 32'(cdb_rob_idx), 32'h0);
    chk("idle_preg", 32'(cdb_preg), 32'h0);
    chk("idle_result", cdb_result, 32'h0);
    chk("idle_fu_ready", 32'(seen_rdy), 32'h0);

    // Single request from FU2.
    set_pay(2, 4'd5, 6'd12, 32'hDEADBEEF);
    fu_valid = 4'b0100; cdb_ready = 1'b1;
    cycle();
    chk("single_ready", 32'(seen_rdy), 32'h4);
    chk("single_valid", 32'(cdb_valid), 32'h1);
    chk("single_rob", 32'(cdb_rob_idx), 32'd5);
    chk("single_preg", 32'(cdb_preg), 32'd12);
    chk("single_result", cdb_result, 32'hDEADBEEF);
    chk("single_ptr", 32'(dut.rr_ptr), 32'd3);
    fu_valid = 4'b0000;
    cycle();
    chk("drain_valid", 32'(cdb_valid), 32'h0);

    // Table: round-robin, backpressure, flush, reset-over-flush.
    for (int i = 0; i < N; i++) set_pay(i, 4'(i + 3), 6'(i + 10), 32'hC0DE0000 + 32'(i));
    for (int r = 0; r < 18; r++) begin
      rst_n = tbl[r].rst; flush = tbl[r].fl;
      fu_valid = tbl[r].val; cdb_ready = tbl[r].crdy;
      cycle();
      chk($sformatf("tbl%0d_ready", r), 32'(seen_rdy), 32'(tbl[r].exp_ready));
      chk($sformatf("tbl%0d_valid", r), 32'(cdb_valid), 32'(tbl[r].exp_cv));
      if (tbl[r].exp_src >= 0) begin
        chk($sformatf("tbl%0d_rob", r), 32'(cdb_rob_idx), 32'(tbl[r].exp_src + 3));
        chk($sformatf("tbl%0d_result", r), cdb_result, 32'hC0DE0000 + 32'(tbl[r].exp_src));
      end
      chk($sformatf("tbl%0d_ptr", r), 32'(dut.rr_ptr), 32'(tbl[r].exp_ptr));
    end
    rst_n = 1'b1; flush = 1'b0;

`ifdef CDB_STALL_CNT_EN
    // One accepted packet, then nine stalled edges.
    fu_valid = 4'b0001; cdb_ready = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    chk("stall_nine", 32'(stall_cnt), 32'd9);
    flush = 1'b1;
    cycle();
    chk("stall_flush", 32'(stall_cnt), 32'd0);
    flush = 1'b0;
`endif

    // Randomized run: FUs hold valid/payload until their transfer.
    pend = '0;
    fu_valid = '0;
    for (int c = 0; c < 800; c++) begin
      rst_n     = ($urandom_range(99) != 0);
      flush     = ($urandom_range(24) == 0);
      cdb_ready = ($urandom_range(2) != 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(1) == 1) begin
          pend[i] = 1'b1;
          set_pay(i, 4'($urandom), 6'($urandom), $urandom);
        end
      end
      fu_valid = pend;
      cycle();
      pend = pend & ~exp_rdy;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
